usrt_tx: RTL and testbench

Serial transmitter that consumes the status register's configuration: 14-bit clocks-per-bit count and parity type. It accepts bytes over a valid/ready handshake into a one-deep holding buffer, then shifts them out on a single line. Frame format is start bit, 8 data bits LSB first, parity bit, then STOP_BITS stop bits. It sits directly downstream of the status register, on the APB clock domain.

---
 rtl/usrt_tx_if.sv | 9 +
 rtl/usrt_tx.sv | 161 ++++++++++++++++
 tb/tb_usrt_tx.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/usrt_tx_if.sv
// Byte handshake between a producer and the usrt_tx holding buffer.
interface usrt_tx_if;
  logic [7:0] i_Tx_Data;
  logic       i_Tx_Valid;
  logic       o_Tx_Ready;

  modport master (output i_Tx_Data, output i_Tx_Valid, input o_Tx_Ready);
  modport slave  (input i_Tx_Data, input i_Tx_Valid, output o_Tx_Ready);
endinterface

// File: rtl/usrt_tx.sv
// Serial transmitter: one-deep holding buffer feeding a start/8 data/parity/stop framer.
// Baud and parity are captured per frame at launch so config changes never disturb a frame in flight.
module usrt_tx #(
  parameter int unsigned STOP_BITS = 1
) (
  input  logic        i_Pclk,
  input  logic        i_Reset,
  input  logic [13:0] i_Baud,
  input  logic        i_Parity,
  usrt_tx_if.slave    tx_if,
  output logic        o_Tx,
  output logic        o_Busy,
  output logic        o_Done
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic STOP_LAST = (STOP_BITS == 2);

  state_t      state_q, state_d;
  logic        buf_full_q, buf_full_d;
  logic [7:0]  buf_q, buf_d;
  logic [7:0]  data_q, data_d;
  logic [13:0] baud_q, baud_d;
  logic        par_q, par_d;
  logic [13:0] timer_q, timer_d;
  logic [2:0]  idx_q, idx_d;
  logic        stop_q, stop_d;
  logic        tx_q, tx_d;
  logic        done_q, done_d;

  logic        wr;
  logic        launch;
  logic        tick0;
  logic [13:0] period_in;

  assign wr        = tx_if.i_Tx_Valid & ~buf_full_q;
  assign tick0     = (timer_q == '0);
  assign period_in = (i_Baud < 14'd2) ? 14'd2 : i_Baud;

  always_comb begin
    state_d    = state_q;
    buf_full_d = buf_full_q;
    buf_d      = buf_q;
    data_d     = data_q;
    baud_d     = baud_q;
    par_d      = par_q;
    timer_d    = timer_q;
    idx_d      = idx_q;
    stop_d     = stop_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    launch     = 1'b0;

    if (wr) begin
      buf_full_d = 1'b1;
      buf_d      = tx_if.i_Tx_Data;
    end

    if (state_q != IDLE) begin
      timer_d = tick0 ? (baud_q - 14'd1) : (timer_q - 14'd1);
    end

    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (buf_full_q) launch = 1'b1;
      end
      START: begin
        if (tick0) begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = data_q[0];
        end
      end
      DATA: begin
        if (tick0) begin
          if (idx_q == 3'd7) begin
            state_d = PARITY;
            tx_d    = (^data_q) ^ par_q;
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = data_q[idx_d];
          end
        end
      end
      PARITY: begin
        if (tick0) begin
          state_d = STOP;
          stop_d  = 1'b0;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (tick0) begin
          if (stop_q == STOP_LAST) begin
            done_d = 1'b1;
            if (buf_full_q) begin
              launch = 1'b1;
            end else begin
              state_d = IDLE;
              timer_d = '0;
              tx_d    = 1'b1;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Launch needs a full buffer and a write needs an empty one, so this override never drops a write.
    if (launch) begin
      state_d    = START;
      buf_full_d = 1'b0;
      data_d     = buf_q;
      baud_d     = period_in;
      par_d      = i_Parity;
      timer_d    = period_in - 14'd1;
      tx_d       = 1'b0;
    end
  end

  always_ff @(posedge i_Pclk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q    <= IDLE;
      buf_full_q <= 1'b0;
      buf_q      <= '0;
      data_q     <= '0;
      baud_q     <= '0;
      par_q      <= 1'b0;
      timer_q    <= '0;
      idx_q      <= '0;
      stop_q     <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_full_q <= buf_full_d;
      buf_q      <= buf_d;
      data_q     <= data_d;
      baud_q     <= baud_d;
      par_q      <= par_d;
      timer_q    <= timer_d;
      idx_q      <= idx_d;
      stop_q     <= stop_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  assign tx_if.o_Tx_Ready = ~buf_full_q;
  assign o_Tx             = tx_q;
  assign o_Busy           = (state_q != IDLE);
  assign o_Done           = done_q;

endmodule

// File: tb/tb_usrt_tx.sv
// Directed bench for usrt_tx: one instance with one stop bit, one with two stop bits.
module tb_usrt_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] baud;
  logic        parity;
  logic [7:0]  data;
  logic        valid;
  logic        sel;

  logic tx1, busy1, done1;
  logic tx2, busy2, done2;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  usrt_tx_if if1 ();
  usrt_tx_if if2 ();

  assign if1.i_Tx_Data  = data;
  assign if1.i_Tx_Valid = valid & ~sel;
  assign if2.i_Tx_Data  = data;
  assign if2.i_Tx_Valid = valid & sel;

  usrt_tx #(.STOP_BITS(1)) dut1 (
    .i_Pclk   (clk),
    .i_Reset  (rst),
    .i_Baud   (baud),
    .i_Parity (parity),
    .tx_if    (if1.slave),
    .o_Tx     (tx1),
    .o_Busy   (busy1),
    .o_Done   (done1)
  );

  usrt_tx #(.STOP_BITS(2)) dut2 (
    .i_Pclk   (clk),
    .i_Reset  (rst),
    .i_Baud   (baud),
    .i_Parity (parity),
    .tx_if    (if2.slave),
    .o_Tx     (tx2),
    .o_Busy   (busy2),
    .o_Done   (done2)
  );

  logic o_tx, o_busy, o_done, o_ready;
  assign o_tx    = sel ? tx2   : tx1;
  assign o_busy  = sel ? busy2 : busy1;
  assign o_done  = sel ? done2 : done1;
  assign o_ready = sel ? if2.o_Tx_Ready : if1.o_Tx_Ready;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Handshake from idle; returns on cycle 0 of the start bit.
  task automatic send(input string tag, input logic [7:0] b);
    data  = b;
    valid = 1'b1;
    tick;
    valid = 1'b0;
    chk({tag, "_hs_ready"}, o_ready, 1'b0);
    chk({tag, "_hs_tx"},    o_tx,    1'b1);
    chk({tag, "_hs_busy"},  o_busy,  1'b0);
    tick;
    chk({tag, "_launch_tx"},    o_tx,    1'b0);
    chk({tag, "_launch_ready"}, o_ready, 1'b1);
    chk({tag, "_launch_busy"},  o_busy,  1'b1);
  endtask

  // Checks each bit level at its first and last cycle; off = cycles of bit 0 already elapsed.
  task automatic check_frame(input string tag, input logic [7:0] d, input logic p,
                             input int unsigned per, input int unsigned nstop,
                             input int unsigned off, input logic rdy, input bit b2b);
    logic [11:0] fr;
    int unsigned nbits;
    fr    = {1'b1, 1'b1, p, d, 1'b0};
    nbits = 10 + nstop;
    for (int unsigned k = 0; k < nbits; k++) begin
      if (!(k == 0 && off > 0)) chk($sformatf("%s_b%0d_first", tag, k), o_tx, fr[k]);
      repeat (per - 1 - ((k == 0) ? off : 0)) tick;
      chk($sformatf("%s_b%0d_last", tag, k),  o_tx,    fr[k]);
      chk($sformatf("%s_b%0d_done", tag, k),  o_done,  1'b0);
      chk($sformatf("%s_b%0d_busy", tag, k),  o_busy,  1'b1);
      chk($sformatf("%s_b%0d_ready", tag, k), o_ready, rdy);
      tick;
    end
    chk({tag, "_end_done"},  o_done,  1'b1);
    chk({tag, "_end_ready"}, o_ready, 1'b1);
    if (!b2b) begin
      chk({tag, "_end_tx"},   o_tx,   1'b1);
      chk({tag, "_end_busy"}, o_busy, 1'b0);
      tick;
      chk({tag, "_done_fall"}, o_done, 1'b0);
    end
  endtask

  initial begin
    rst    = 1'b1;
    baud   = '0;
    parity = 1'b0;
    data   = '0;
    valid  = 1'b0;
    sel    = 1'b0;
    #1;
    chk("rst_tx",    o_tx,    1'b1);
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_busy",  o_busy,  1'b0);
    chk("rst_done",  o_done,  1'b0);
    chk("rst_tx2",   tx2,     1'b1);
    tick;
    tick;
    rst = 1'b0;
    tick;

    // Even parity, long bit period
    baud = 14'd1041; parity = 1'b0;
    send("t1", 8'hA5);
    check_frame("t1", 8'hA5, 1'b0, 1041, 1, 0, 1'b1, 1'b0);

    // Odd parity
    baud = 14'd10; parity = 1'b1;
    send("t2a", 8'hA5);
    check_frame("t2a", 8'hA5, 1'b1, 10, 1, 0, 1'b1, 1'b0);
    send("t2b", 8'h01);
    check_frame("t2b", 8'h01, 1'b0, 10, 1, 0, 1'b1, 1'b0);

    // Back-to-back: second byte accepted one edge after the first launch
    baud = 14'd86; parity = 1'b0;
    data = 8'h00; valid = 1'b1;
    tick;
    data = 8'hFF;
    chk("t3_hs_ready", o_ready, 1'b0);
    tick;
    chk("t3_launch_tx", o_tx, 1'b0);
    tick;
    valid = 1'b0;
    chk("t3_second_ready", o_ready, 1'b0);
    check_frame("t3a", 8'h00, 1'b0, 86, 1, 1, 1'b0, 1'b1);
    check_frame("t3b", 8'hFF, 1'b0, 86, 1, 0, 1'b1, 1'b0);

    // Config change during DATA only affects the next frame
    baud = 14'd520; parity = 1'b0;
    send("t4a", 8'h3C);
    fork
      check_frame("t4a", 8'h3C, 1'b0, 520, 1, 0, 1'b1, 1'b0);
      begin
        repeat (520 * 3 + 7) tick;
        baud   = 14'd86;
        parity = 1'b1;
      end
    join
    send("t4b", 8'h3C);
    check_frame("t4b", 8'h3C, 1'b1, 86, 1, 0, 1'b1, 1'b0);

    // Clamp and two stop bits
    sel = 1'b1;
    baud = 14'd0; parity = 1'b0;
    send("t5a", 8'h5A);
    check_frame("t5a", 8'h5A, 1'b0, 2, 2, 0, 1'b1, 1'b0);
    baud = 14'd1;
    send("t5b", 8'h00);
    check_frame("t5b", 8'h00, 1'b0, 2, 2, 0, 1'b1, 1'b0);
    sel = 1'b0;

    // Reset during data bit 3 with the buffer full
    baud = 14'd10; parity = 1'b0;
    send("t6", 8'h96);
    data = 8'h11; valid = 1'b1;
    tick;
    valid = 1'b0;
    chk("t6_buf_full", o_ready, 1'b0);
    repeat (44) tick;
    chk("t6_pre_busy", o_busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("t6_rst_tx",    o_tx,    1'b1);
    chk("t6_rst_ready", o_ready, 1'b1);
    chk("t6_rst_busy",  o_busy,  1'b0);
    chk("t6_rst_done",  o_done,  1'b0);
    tick;
    chk("t6_rst_done2", o_done, 1'b0);
    rst = 1'b0;
    tick;
    chk("t6_post_busy",  o_busy,  1'b0);
    chk("t6_post_tx",    o_tx,    1'b1);
    chk("t6_post_done",  o_done,  1'b0);
    tick;
    chk("t6_post_busy2", o_busy,  1'b0);
    chk("t6_post_ready", o_ready, 1'b1);
    send("t6b", 8'hC3);
    check_frame("t6b", 8'hC3, 1'b0, 10, 1, 0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
